// File: rtl/mem_access_stage_if.sv
// Data-bus interface between the MEM stage (master) and data memory (slave).
//   dbus_req   : access request, held until the ready cycle or a timeout
//   dbus_we    : 1 = write
//   dbus_addr  : word-aligned address
//   dbus_wdata : lane-replicated store data
//   dbus_be    : byte enables
//   dbus_ready : memory completes the access this cycle
//   dbus_rdata : read word, valid with dbus_ready
interface mem_access_stage_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ready;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req,
    output dbus_we,
    output dbus_addr,
    output dbus_wdata,
    output dbus_be,
    input  dbus_ready,
    input  dbus_rdata
  );

  modport slave (
    input  dbus_req,
    input  dbus_we,
    input  dbus_addr,
    input  dbus_wdata,
    input  dbus_be,
    output dbus_ready,
    output dbus_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// RISC-V MEM stage: runs loads/stores over a req/ready data bus, builds byte enables,
// sign/zero-extends load data and stalls the pipeline for the duration of an access.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   ALUResult_in        : effective address from EX/MEM
//   WriteData_in        : store data (rs2)
//   MemRead_in/Write_in : load / store request (store wins if both)
//   funct3_in           : access size and signedness
//   dbus                : data bus (master side), outputs registered
//   ReadData_out        : formatted load data to MEM_WB, registered
//   stall_out           : freeze upstream stages, bubble MEM_WB
//   fault_out           : misaligned or illegal access (combinational)
//   bus_error_out       : one-cycle pulse on bus timeout
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_W           = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               ALUResult_in,
  input  logic [31:0]               WriteData_in,
  input  logic                      MemRead_in,
  input  logic                      MemWrite_in,
  input  logic [2:0]                funct3_in,
  mem_access_stage_if.master        dbus,
  output logic [31:0]               ReadData_out,
  output logic                      stall_out,
  output logic                      fault_out,
  output logic                      bus_error_out
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  // Load formatting info captured at issue so completion does not depend on EX/MEM.
  logic            load_q, load_d;
  logic [1:0]      lsb_q, lsb_d;
  logic [2:0]      f3_q, f3_d;

  logic        access, is_store, misalign, illegal, fault, issue, timeout;
  logic [31:0] wdata_fmt, load_fmt;
  logic [3:0]  be_fmt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign access   = MemRead_in | MemWrite_in;
  assign is_store = MemWrite_in;

  always_comb begin
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3_in)
      3'b000:  ;
      3'b001:  misalign = ALUResult_in[0];
      3'b010:  misalign = |ALUResult_in[1:0];
      3'b100:  illegal  = is_store;
      3'b101: begin
        illegal  = is_store;
        misalign = ALUResult_in[0];
      end
      default: illegal  = 1'b1;
    endcase
  end

  assign fault     = illegal | misalign;
  assign fault_out = access & fault;
  assign issue     = (state_q == StIdle) & access & ~fault;
  assign timeout   = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Store lane replication and byte enables; loads always read the full word.
  always_comb begin
    wdata_fmt = WriteData_in;
    be_fmt    = 4'b1111;
    if (is_store) begin
      case (funct3_in[1:0])
        2'b00: begin
          wdata_fmt = {4{WriteData_in[7:0]}};
          be_fmt    = 4'b0001 << ALUResult_in[1:0];
        end
        2'b01: begin
          wdata_fmt = {2{WriteData_in[15:0]}};
          be_fmt    = ALUResult_in[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (lsb_q)
      2'd0:    byte_sel = dbus.dbus_rdata[7:0];
      2'd1:    byte_sel = dbus.dbus_rdata[15:8];
      2'd2:    byte_sel = dbus.dbus_rdata[23:16];
      default: byte_sel = dbus.dbus_rdata[31:24];
    endcase
    half_sel = lsb_q[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_fmt = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
      default: load_fmt = dbus.dbus_rdata;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (issue) state_d = StBusy;
      StBusy:  if (dbus.dbus_ready || timeout) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs. DONE releases the stall so MEM_WB captures ReadData_out at its edge.
  always_comb begin
    stall_out = 1'b0;
    case (state_q)
      StIdle:  stall_out = issue;
      StBusy:  stall_out = 1'b1;
      default: stall_out = 1'b0;
    endcase
  end

  // Datapath next state
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    lsb_d   = lsb_q;
    f3_d    = f3_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (issue) begin
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {ALUResult_in[31:2], 2'b00};
          wdata_d = wdata_fmt;
          be_d    = be_fmt;
          cnt_d   = '0;
          load_d  = ~is_store;
          lsb_d   = ALUResult_in[1:0];
          f3_d    = funct3_in;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + TO_W'(1);
        if (dbus.dbus_ready) begin
          req_d = 1'b0;
          if (load_q) rdata_d = load_fmt;
        end else if (timeout) begin
          req_d   = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      lsb_q   <= '0;
      f3_q    <= '0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      lsb_q   <= lsb_d;
      f3_q    <= f3_d;
    end
  end

  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_wdata = wdata_q;
  assign dbus.dbus_be    = be_q;
  assign ReadData_out    = rdata_q;
  assign bus_error_out   = err_q;

endmodule
